fir_mac_engine: RTL and testbench
=================================

# fir_mac_engine

Parametrised, multi-channel, time-multiplexed FIR filter core that succeeds the fixed 11-tap/8-bit engine behind the I2S and SPI front ends. One signed multiply-accumulate per cycle serves NChannels independent delay lines. Coefficients are double-buffered so a host can reload them without corrupting a filter pass in progress. The block sits between the I2S deserialiser (sample source), the I2S serialiser (sample sink) and the SPI register file (coefficient writer).

## Interface
- NTaps, 11, number of taps per channel (≥2)
- DataWidth, 8, signed sample width in and out
- CoeffWidth, 8, signed coefficient width, Q1.(CoeffWidth-1) format
- NChannels, 2, independent channels sharing one MAC (≥1)
- AccWidth, DataWidth+CoeffWidth+$clog2(NTaps), accumulator width (derived, not overridden)

- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- inValid  in  1  sample offered
- inReady  out  1  core can accept a sample this cycle
- inData  in  DataWidth  signed sample
- inChannel  in  max(1,$clog2(NChannels))  channel of inData
- outValid  out  1  one-cycle pulse, outData/outChannel valid
- outData  out  DataWidth  signed filtered sample
- outChannel  out  max(1,$clog2(NChannels))  channel of outData
- coeffWe  in  1  write coeffData into shadow bank at coeffAddr
- coeffAddr  in  max(1,$clog2(NTaps))  tap index
- coeffData  in  CoeffWidth  signed coefficient
- coeffCommit  in  1  request shadow→active bank copy
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, MAC, ROUND, COPY.
- IDLE: inReady=1 unless commit pending. Handshake = inValid & inReady. On handshake with inChannel < NChannels: shift that channel's delay line (tap k ← tap k-1, tap 0 ← inData), latch channel, clear acc, k←0, go MAC. On handshake with inChannel ≥ NChannels: sample discarded, stay IDLE, no output.
- IDLE with commit pending: go COPY (inReady=0 this cycle).
- COPY: active[k] ← shadow[k] for all k in one cycle, clear pending, return IDLE.
- MAC: acc += active[k] * tap[ch][k] (full signed product, sign-extended to AccWidth); k increments; after k=NTaps-1 go ROUND. Exactly NTaps MAC cycles.
- ROUND: r = (acc + 2^(CoeffWidth-2)) >>> (CoeffWidth-1) (round half up, arithmetic shift); saturate to [-2^(DataWidth-1), 2^(DataWidth-1)-1]; register into outData, outChannel=latched channel, outValid=1 for the next cycle; go IDLE.
- Coefficient writes to shadow bank accepted in every state; coeffAddr ≥ NTaps ignored. coeffCommit sets pending in any state; commit while already pending has no extra effect. Write and commit in the same cycle: the write is included in the copy (copy occurs no earlier than the following cycle).
- Active bank never changes during MAC/ROUND; a commit during a pass takes effect after that pass's output.
- Delay lines of other channels are untouched by a pass.

## Timing
- Reset (synchronous, priority over everything): FSM→IDLE, all delay-line taps, shadow and active coefficients, acc, pending cleared to 0; outValid=0, outData=0, outChannel=0, busy=0, inReady=1 on the first cycle after reset deasserts.
- Latency: handshake at edge N → outValid high during cycle N+NTaps+2 (1 cycle load, NTaps MAC, 1 ROUND-register); inReady returns high the same cycle outValid is high (unless commit pending).
- Throughput: one sample per NTaps+2 cycles; NChannels samples occupy NChannels×(NTaps+2) cycles.
- Reset asserted mid-pass: pass abandoned, no outValid, delay lines zeroed.
- outValid is never held; downstream must sample it in its single cycle.

## Test plan
- Impulse: NTaps=11, coeffs k=0..10 = 1..11 (shadow writes, commit), channel 0 feed 64 then ten 0s → outputs round(64·(k+1)/128) = 1,1,2,2,3,3,4,4,5,5,6 (half-up), each exactly 13 cycles after its handshake.
- Channel isolation: NChannels=2, coeff[0]=127 others 0; feed ch0=100, ch1=-50 alternately → ch0 outputs 99, ch1 outputs -50 (rounded), outChannel matches, no cross-talk.
- Saturation: all coeffs 127, feed eleven 127s → final output 127; all -128 samples with coeff 127 → -128.
- Deferred commit: during MAC of a sample, write new coeffs and pulse coeffCommit → that sample uses old bank; busy stays high, next IDLE shows one COPY cycle with inReady=0; next sample uses new bank.
- Reset mid-pass: assert reset during MAC cycle 5 → no outValid, all outputs 0, subsequent impulse response starts from empty delay line with zero coefficients (output 0).
- Illegal indices: inChannel=3 with NChannels=2 → handshake completes, no outValid; coeffAddr=12 write → active bank unchanged after commit.

Source files
------------

// File: rtl/fir_mac_engine.sv
`timescale 1ns/1ps
// Time-multiplexed multi-channel FIR core: one signed MAC per cycle shared by all
// channels, with a double-buffered coefficient bank that is only swapped between passes.
module fir_mac_engine #(
    parameter int unsigned NTaps      = 11,
    parameter int unsigned DataWidth  = 8,
    parameter int unsigned CoeffWidth = 8,
    parameter int unsigned NChannels  = 2,
    localparam int unsigned AccWidth  = DataWidth + CoeffWidth + $clog2(NTaps),
    localparam int unsigned ChW       = (NChannels > 1) ? $clog2(NChannels) : 1,
    localparam int unsigned AddrW     = (NTaps > 1) ? $clog2(NTaps) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inValid,
    output logic                         inReady,
    input  logic signed [DataWidth-1:0]  inData,
    input  logic [ChW-1:0]               inChannel,
    output logic                         outValid,
    output logic signed [DataWidth-1:0]  outData,
    output logic [ChW-1:0]               outChannel,
    input  logic                         coeffWe,
    input  logic [AddrW-1:0]             coeffAddr,
    input  logic signed [CoeffWidth-1:0] coeffData,
    input  logic                         coeffCommit,
    output logic                         busy
);

    localparam int unsigned ProdW = DataWidth + CoeffWidth;
    localparam int unsigned SumW  = AccWidth + 1;

    localparam int RoundI  = 1 << (CoeffWidth - 2);
    localparam int OutMaxI = (1 << (DataWidth - 1)) - 1;
    localparam int OutMinI = -(1 << (DataWidth - 1));

    localparam logic signed [SumW-1:0] RoundBias = SumW'(RoundI);
    localparam logic signed [SumW-1:0] OutMax    = SumW'(OutMaxI);
    localparam logic signed [SumW-1:0] OutMin    = SumW'(OutMinI);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_COPY  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       pending;
    logic       pending_nxt;

    logic [ChW-1:0]              ch_q;
    logic [AddrW-1:0]            k_q;
    logic signed [AccWidth-1:0]  acc;

    logic signed [DataWidth-1:0]  taps   [NChannels][NTaps];
    logic signed [CoeffWidth-1:0] shadow [NTaps];
    logic signed [CoeffWidth-1:0] active [NTaps];

    logic                        handshake_c;
    logic                        ch_legal_c;
    logic                        addr_legal_c;
    logic                        last_tap_c;
    logic                        accept_c;
    logic signed [ProdW-1:0]     prod_c;
    logic signed [SumW-1:0]      biased_c;
    logic signed [SumW-1:0]      shifted_c;
    logic signed [DataWidth-1:0] sat_c;

    assign handshake_c  = inValid & inReady;
    assign ch_legal_c   = 32'(inChannel) < NChannels;
    assign addr_legal_c = 32'(coeffAddr) < NTaps;
    assign last_tap_c   = 32'(k_q) == (NTaps - 1);
    assign accept_c     = (state == S_IDLE) && !pending && handshake_c && ch_legal_c;

    // Full-width signed product; both operands sign-extend before the multiply.
    assign prod_c    = ProdW'(active[k_q]) * ProdW'(taps[ch_q][k_q]);
    assign biased_c  = SumW'(acc) + RoundBias;
    assign shifted_c = biased_c >>> (CoeffWidth - 1);

    always_comb begin
        sat_c = DataWidth'(shifted_c);
        if (shifted_c > OutMax) begin
            sat_c = DataWidth'(OutMax);
        end else if (shifted_c < OutMin) begin
            sat_c = DataWidth'(OutMin);
        end
    end

    // Next-state and commit-pending logic; a new commit wins over the clear in COPY.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        if (coeffCommit) begin
            pending_nxt = 1'b1;
        end else if (state == S_COPY) begin
            pending_nxt = 1'b0;
        end
        case (state)
            S_IDLE: begin
                if (pending) begin
                    state_nxt = S_COPY;
                end else if (handshake_c && ch_legal_c) begin
                    state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (last_tap_c) begin
                    state_nxt = S_ROUND;
                end
            end
            S_ROUND: state_nxt = S_IDLE;
            S_COPY:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pending <= 1'b0;
            busy    <= 1'b0;
            inReady <= 1'b1;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            busy    <= state_nxt != S_IDLE;
            inReady <= (state_nxt == S_IDLE) && !pending_nxt;
        end
    end

    // Shadow bank takes writes in any state; active bank only changes in COPY.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(NTaps); k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            if (coeffWe && addr_legal_c) begin
                shadow[coeffAddr] <= coeffData;
            end
            if (state == S_COPY) begin
                for (int k = 0; k < int'(NTaps); k++) begin
                    active[k] <= shadow[k];
                end
            end
        end
    end

    // Only the accepted channel's delay line shifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < int'(NChannels); c++) begin
                for (int k = 0; k < int'(NTaps); k++) begin
                    taps[c][k] <= '0;
                end
            end
        end else if (accept_c) begin
            for (int k = int'(NTaps) - 1; k > 0; k--) begin
                taps[inChannel][k] <= taps[inChannel][k-1];
            end
            taps[inChannel][0] <= inData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            k_q        <= '0;
            ch_q       <= '0;
            outValid   <= 1'b0;
            outData    <= '0;
            outChannel <= '0;
        end else begin
            outValid <= 1'b0;
            if (accept_c) begin
                acc  <= '0;
                k_q  <= '0;
                ch_q <= inChannel;
            end
            if (state == S_MAC) begin
                acc <= acc + AccWidth'(prod_c);
                if (!last_tap_c) begin
                    k_q <= k_q + AddrW'(1);
                end
            end
            if (state == S_ROUND) begin
                outValid   <= 1'b1;
                outData    <= sat_c;
                outChannel <= ch_q;
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
`timescale 1ns/1ps
// Bench for fir_mac_engine: an arithmetic reference model predicts every output pulse
// and its cycle; directed tests pin selected results to hand-computed literals.
module tb_fir_mac_engine;

    localparam int NT  = 11;
    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int NCH = 3;
    localparam int CHW = 2;
    localparam int AW  = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 inValid = 1'b0;
    logic                 inReady;
    logic signed [DW-1:0] inData = '0;
    logic [CHW-1:0]       inChannel = '0;
    logic                 outValid;
    logic signed [DW-1:0] outData;
    logic [CHW-1:0]       outChannel;
    logic                 coeffWe = 1'b0;
    logic [AW-1:0]        coeffAddr = '0;
    logic signed [CW-1:0] coeffData = '0;
    logic                 coeffCommit = 1'b0;
    logic                 busy;

    fir_mac_engine #(
        .NTaps(NT), .DataWidth(DW), .CoeffWidth(CW), .NChannels(NCH)
    ) dut (
        .clk(clk), .reset(reset),
        .inValid(inValid), .inReady(inReady), .inData(inData), .inChannel(inChannel),
        .outValid(outValid), .outData(outData), .outChannel(outChannel),
        .coeffWe(coeffWe), .coeffAddr(coeffAddr), .coeffData(coeffData),
        .coeffCommit(coeffCommit), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int due;
        int data;
        int ch;
    } exp_t;
    exp_t exp_q[$];

    int m_taps [NCH][NT];
    int m_shadow [NT];
    int m_committed [NT];
    int m_active [NT];
    bit m_pending;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < NT; k++) m_taps[c][k] = 0;
        for (int k = 0; k < NT; k++) begin
            m_shadow[k] = 0;
            m_committed[k] = 0;
            m_active[k] = 0;
        end
        m_pending = 1'b0;
        exp_q.delete();
    endfunction

    function automatic int model_filter(int ch);
        int acc = 0;
        int r;
        for (int k = 0; k < NT; k++) acc += m_active[k] * m_taps[ch][k];
        r = (acc + (1 << (CW - 2))) >>> (CW - 1);
        if (r > (1 << (DW - 1)) - 1) r = (1 << (DW - 1)) - 1;
        if (r < -(1 << (DW - 1))) r = -(1 << (DW - 1));
        return r;
    endfunction

    // A sample sees the bank from the last commit issued before its handshake cycle.
    function automatic void model_accept(int ch, int d, int h);
        exp_t e;
        if (ch >= NCH) return;
        if (m_pending) begin
            m_active = m_committed;
            m_pending = 1'b0;
        end
        for (int k = NT - 1; k > 0; k--) m_taps[ch][k] = m_taps[ch][k-1];
        m_taps[ch][0] = d;
        e.due = h + NT + 2;
        e.data = model_filter(ch);
        e.ch = ch;
        exp_q.push_back(e);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    bit mon_en = 1'b0;
    int out_count = 0;
    int last_data = 0;
    int last_ch = 0;
    int last_cyc = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                checks++;
                if (outValid !== 1'b1 || int'(outData) != exp_q[0].data ||
                    int'(outChannel) != exp_q[0].ch) begin
                    errors++;
                    $display("FAIL stream cycle %0d: valid=%b data=%0d ch=%0d, expected valid=1 data=%0d ch=%0d",
                             cyc, outValid, outData, outChannel, exp_q[0].data, exp_q[0].ch);
                end
                void'(exp_q.pop_front());
            end else begin
                checks++;
                if (outValid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream cycle %0d: outValid=%b, expected 0", cyc, outValid);
                end
            end
            if (outValid === 1'b1) begin
                out_count++;
                last_data = int'(outData);
                last_ch = int'(outChannel);
                last_cyc = cyc;
            end
        end
    end

    task automatic write_coef(input int addr, input int val, input bit commit = 1'b0);
        coeffWe = 1'b1;
        coeffAddr = AW'(addr);
        coeffData = CW'(val);
        coeffCommit = commit;
        if (addr < NT) m_shadow[addr] = val;
        if (commit) begin
            m_committed = m_shadow;
            m_pending = 1'b1;
        end
        @(negedge clk);
        coeffWe = 1'b0;
        coeffCommit = 1'b0;
    endtask

    task automatic commit_only();
        coeffCommit = 1'b1;
        m_committed = m_shadow;
        m_pending = 1'b1;
        @(negedge clk);
        coeffCommit = 1'b0;
    endtask

    // Called at a negedge; returns one negedge after the handshake cycle.
    task automatic send(input int ch, input int d, output int h);
        int waited = 0;
        inValid = 1'b1;
        inData = DW'(d);
        inChannel = CHW'(ch);
        while (inReady !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: inReady=%b after %0d cycles, expected 1", inReady, waited);
            h = -1;
            inValid = 1'b0;
            return;
        end
        h = cyc;
        model_accept(ch, d, h);
        @(negedge clk);
        inValid = 1'b0;
    endtask

    task automatic expect_out(input string name, input int h, input int data, input int ch);
        repeat (NT + 2) @(negedge clk);
        check({name, "_data"}, last_data, data);
        check({name, "_ch"}, last_ch, ch);
        check({name, "_latency"}, last_cyc - h, 13);
    endtask

    int h;
    int oc;
    int n;
    int imp_exp [NT] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6};

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        check("rst_outValid", int'(outValid), 0);
        check("rst_outData", int'(outData), 0);
        check("rst_outChannel", int'(outChannel), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_inReady", int'(inReady), 1);

        // Impulse response; last coefficient written in the same cycle as the commit.
        for (int k = 0; k < NT - 1; k++) write_coef(k, k + 1);
        write_coef(NT - 1, NT, 1'b1);
        for (int i = 0; i < NT; i++) begin
            send(0, (i == 0) ? 64 : 0, h);
            expect_out($sformatf("impulse%0d", i), h, imp_exp[i], 0);
        end

        // Channel isolation with a single-tap pass-through bank.
        write_coef(0, 127);
        for (int k = 1; k < NT; k++) write_coef(k, 0);
        commit_only();
        for (int rep = 0; rep < 2; rep++) begin
            send(0, 100, h);
            expect_out($sformatf("iso_ch0_%0d", rep), h, 99, 0);
            send(1, -50, h);
            expect_out($sformatf("iso_ch1_%0d", rep), h, -50, 1);
        end

        // Out-of-range coefficient address must not disturb the bank.
        write_coef(12, 5, 1'b1);
        send(0, 100, h);
        expect_out("bad_addr", h, 99, 0);

        // Out-of-range channel: handshake taken, no pass started.
        oc = out_count;
        send(3, 77, h);
        check("bad_ch_handshake", int'(h >= 0), 1);
        check("bad_ch_busy", int'(busy), 0);
        repeat (NT + 3) @(negedge clk);
        check("bad_ch_no_output", out_count, oc);
        check("bad_ch_ready", int'(inReady), 1);

        // Commit during a pass is deferred until after that pass's output.
        send(1, 40, h);
        check("defer_busy", int'(busy), 1);
        write_coef(0, 64, 1'b1);
        n = 0;
        while (outValid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("defer_old_bank", int'(outData), 40);
        check("defer_ready_on_out", int'(inReady), 0);
        @(negedge clk);
        check("copy_ready", int'(inReady), 0);
        check("copy_busy", int'(busy), 1);
        @(negedge clk);
        check("post_copy_ready", int'(inReady), 1);
        check("post_copy_busy", int'(busy), 0);
        send(1, 40, h);
        expect_out("defer_new_bank", h, 20, 1);

        // Saturation, back-to-back samples on a fresh channel.
        for (int k = 0; k < NT; k++) write_coef(k, 127);
        commit_only();
        for (int i = 0; i < NT; i++) send(2, 127, h);
        repeat (NT + 2) @(negedge clk);
        check("sat_pos", last_data, 127);
        for (int i = 0; i < NT; i++) send(2, -128, h);
        repeat (NT + 2) @(negedge clk);
        check("sat_neg", last_data, -128);

        // Reset during MAC cycle 5 abandons the pass and clears all state.
        send(0, 50, h);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_outValid", int'(outValid), 0);
        check("midrst_outData", int'(outData), 0);
        check("midrst_outChannel", int'(outChannel), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_inReady", int'(inReady), 1);
        oc = out_count;
        send(0, 64, h);
        expect_out("midrst_impulse", h, 0, 0);
        check("midrst_one_pulse", out_count, oc + 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
